fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 16 +
 rtl/fetch_ctrl_if.sv | 23 ++
 rtl/fetch_ctrl_pc.sv | 24 ++
 rtl/fetch_ctrl.sv | 84 ++++++++
 tb/tb_fetch_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encodings, default reset PC and address alignment helper.
//   state_t      - 2-bit fetch FSM state encoding
//   RESET_PC_DEF - default first fetch address
//   align()      - clears the byte-offset bits of an address
package fetch_ctrl_pkg;
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   function automatic logic [31:0] align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory request/response bus plus downstream instruction handoff.
//   imem_req/imem_addr/imem_gnt     - request channel (master drives req/addr)
//   imem_rvalid/imem_rdata          - single-cycle response channel
//   inst_valid/inst/inst_pc/inst_ready - held instruction handoff to the consumer
interface fetch_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   modport master (
      output imem_req, imem_addr, inst_valid, inst, inst_pc,
      input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
   );
   modport slave (
      input  imem_req, imem_addr, inst_valid, inst, inst_pc,
      output imem_gnt, imem_rvalid, imem_rdata, inst_ready
   );
endinterface

// File: rtl/fetch_ctrl_pc.sv
// fetch_ctrl_pc: program counter register with next-pc select (redirect > +4 > hold).
//   clk, rst        - clock, asynchronous active-high reset
//   i_redirect      - load aligned i_redirect_pc
//   i_redirect_pc   - redirect target
//   i_inc           - advance by one word
//   o_pc            - current fetch address
module fetch_ctrl_pc
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_inc,
   output logic [31:0] o_pc
);
   logic [31:0] r_pc;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_pc <= RESET_PC;
      else     r_pc <= i_redirect ? align(i_redirect_pc) : i_inc ? r_pc + 32'd4 : r_pc;
   assign o_pc = r_pc;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch FSM with one-entry hold buffer and handoff counter.
//   clk, rst          - clock, asynchronous active-high reset
//   i_redirect_valid  - redirect this cycle, overrides every other event
//   i_redirect_pc     - redirect target (low two bits ignored)
//   bus               - memory request/response and downstream handoff (master side)
//   o_fetch_cnt       - number of completed handoffs, wraps modulo 2^32
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_redirect_valid,
   input  logic [31:0]        i_redirect_pc,
   fetch_ctrl_if.master       bus,
   output logic [31:0]        o_fetch_cnt
);
   state_t      r_state;
   logic        r_req;
   logic        r_inst_valid;
   logic [31:0] r_inst;
   logic [31:0] r_inst_pc;
   logic [31:0] r_fetch_cnt;
   logic [31:0] w_pc;
   logic        w_inc;
   // pc only advances on a response that is actually kept
   assign w_inc = (r_state == S_WAIT) && bus.imem_rvalid && !i_redirect_valid;
   fetch_ctrl_pc #(.RESET_PC(RESET_PC)) u_fetch_pc (
      .clk           (clk),
      .rst           (rst),
      .i_redirect    (i_redirect_valid),
      .i_redirect_pc (i_redirect_pc),
      .i_inc         (w_inc),
      .o_pc          (w_pc)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state      <= S_REQ;
         r_req        <= 1'b1;
         r_inst_valid <= 1'b0;
         r_inst       <= '0;
         r_inst_pc    <= '0;
         r_fetch_cnt  <= '0;
      end else begin
         case (r_state)
            // a grant taken together with a redirect belongs to the old address: drain it
            S_REQ: if (bus.imem_gnt) begin
               r_state <= i_redirect_valid ? S_DROP : S_WAIT;
               r_req   <= 1'b0;
            end
            S_WAIT: if (i_redirect_valid) begin
               r_state <= bus.imem_rvalid ? S_REQ : S_DROP;
               r_req   <= bus.imem_rvalid;
            end else if (bus.imem_rvalid) begin
               r_state      <= S_HOLD;
               r_inst_valid <= 1'b1;
               r_inst       <= bus.imem_rdata;
               r_inst_pc    <= w_pc;
            end
            S_HOLD: if (i_redirect_valid || bus.inst_ready) begin
               r_state      <= S_REQ;
               r_req        <= 1'b1;
               r_inst_valid <= 1'b0;
               if (!i_redirect_valid) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            // stay until the stale response returns, even across further redirects
            S_DROP: if (bus.imem_rvalid) begin
               r_state <= S_REQ;
               r_req   <= 1'b1;
            end
            default: begin
               r_state <= S_REQ;
               r_req   <= 1'b1;
            end
         endcase
      end
   assign bus.imem_req   = r_req;
   assign bus.imem_addr  = w_pc;
   assign bus.inst_valid = r_inst_valid;
   assign bus.inst       = r_inst;
   assign bus.inst_pc    = r_inst_pc;
   assign o_fetch_cnt    = r_fetch_cnt;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl (default and wrap-around reset PC instances).
module tb_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redir = 1'b0;
   logic [31:0] redir_pc = '0;
   logic [31:0] cnt;
   logic [31:0] cnt2;
   int          n_vec = 0;
   int          n_err = 0;
   fetch_ctrl_if bus ();
   fetch_ctrl_if bus2 ();
   fetch_ctrl u_dut (
      .clk              (clk),
      .rst              (rst),
      .i_redirect_valid (redir),
      .i_redirect_pc    (redir_pc),
      .bus              (bus),
      .o_fetch_cnt      (cnt)
   );
   fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
      .clk              (clk),
      .rst              (rst),
      .i_redirect_valid (1'b0),
      .i_redirect_pc    (32'h0),
      .bus              (bus2),
      .o_fetch_cnt      (cnt2)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic fetch(input logic [31:0] a, input logic [31:0] d, input bit take, input logic [31:0] c);
      check("req", {31'd0, bus.imem_req}, 32'd1);
      check("addr", bus.imem_addr, a);
      bus.imem_gnt = 1'b1;
      tick;
      bus.imem_gnt = 1'b0;
      check("wait_req", {31'd0, bus.imem_req}, 32'd0);
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = d;
      tick;
      bus.imem_rvalid = 1'b0;
      check("hold_valid", {31'd0, bus.inst_valid}, 32'd1);
      check("inst", bus.inst, d);
      check("inst_pc", bus.inst_pc, a);
      if (take) begin
         bus.inst_ready = 1'b1;
         tick;
         bus.inst_ready = 1'b0;
         check("post_valid", {31'd0, bus.inst_valid}, 32'd0);
         check("cnt", cnt, c);
      end
   endtask
   initial begin
      bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
      bus2.imem_gnt = 1'b0; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0; bus2.inst_ready = 1'b0;
      tick;
      tick;
      check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
      check("rst_inst", bus.inst, 32'd0);
      check("rst_cnt", cnt, 32'd0);
      check("rst_addr", bus.imem_addr, 32'd0);
      rst = 1'b0;
      // sequential fetch with immediate grant and handoff
      fetch(32'h0, 32'hA000_0001, 1'b1, 32'd1);
      fetch(32'h4, 32'hA000_0002, 1'b1, 32'd2);
      fetch(32'h8, 32'hA000_0003, 1'b1, 32'd3);
      // consumer stall in HOLD
      fetch(32'hC, 32'hB000_0004, 1'b0, 32'd3);
      for (int i = 0; i < 5; i++) begin
         tick;
         check("stall_inst", bus.inst, 32'hB000_0004);
         check("stall_pc", bus.inst_pc, 32'hC);
         check("stall_req", {31'd0, bus.imem_req}, 32'd0);
         check("stall_cnt", cnt, 32'd3);
      end
      bus.inst_ready = 1'b1;
      tick;
      bus.inst_ready = 1'b0;
      check("stall_done_cnt", cnt, 32'd4);
      // redirect while waiting, stale response two cycles later
      check("pre_redir_addr", bus.imem_addr, 32'h10);
      bus.imem_gnt = 1'b1;
      tick;
      bus.imem_gnt = 1'b0;
      redir = 1'b1; redir_pc = 32'h100;
      tick;
      redir = 1'b0;
      check("drop_req", {31'd0, bus.imem_req}, 32'd0);
      tick;
      bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
      tick;
      bus.imem_rvalid = 1'b0;
      check("drop_valid", {31'd0, bus.inst_valid}, 32'd0);
      fetch(32'h100, 32'hC000_0100, 1'b1, 32'd5);
      // redirect in HOLD with ready: no handoff, unaligned target
      fetch(32'h104, 32'hC000_0104, 1'b0, 32'd5);
      bus.inst_ready = 1'b1; redir = 1'b1; redir_pc = 32'h203;
      tick;
      bus.inst_ready = 1'b0; redir = 1'b0;
      check("hold_redir_valid", {31'd0, bus.inst_valid}, 32'd0);
      check("hold_redir_cnt", cnt, 32'd5);
      check("hold_redir_addr", bus.imem_addr, 32'h200);
      check("hold_redir_req", {31'd0, bus.imem_req}, 32'd1);
      // redirect in REQ without grant, then with grant
      redir = 1'b1; redir_pc = 32'h300;
      tick;
      redir = 1'b0;
      check("req_redir_addr", bus.imem_addr, 32'h300);
      check("req_redir_req", {31'd0, bus.imem_req}, 32'd1);
      redir = 1'b1; redir_pc = 32'h400; bus.imem_gnt = 1'b1;
      tick;
      redir = 1'b0; bus.imem_gnt = 1'b0;
      check("req_gnt_redir_req", {31'd0, bus.imem_req}, 32'd0);
      bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1111_2222;
      tick;
      bus.imem_rvalid = 1'b0;
      check("req_gnt_redir_addr", bus.imem_addr, 32'h400);
      check("req_gnt_redir_valid", {31'd0, bus.inst_valid}, 32'd0);
      check("req_gnt_redir_cnt", cnt, 32'd5);
      // asynchronous reset while waiting
      bus.imem_gnt = 1'b1;
      tick;
      bus.imem_gnt = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_cnt", cnt, 32'd0);
      check("arst_inst", bus.inst, 32'd0);
      check("arst_pc", bus.inst_pc, 32'd0);
      check("arst_addr", bus.imem_addr, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick;
      check("rel_req", {31'd0, bus.imem_req}, 32'd1);
      check("rel_addr", bus.imem_addr, 32'd0);
      // wrap-around reset PC and counter wrap
      check("w_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
      bus2.imem_gnt = 1'b1;
      tick;
      bus2.imem_gnt = 1'b0;
      bus2.imem_rvalid = 1'b1; bus2.imem_rdata = 32'h1234_5678;
      tick;
      bus2.imem_rvalid = 1'b0;
      check("w_inst_pc", bus2.inst_pc, 32'hFFFF_FFFC);
      check("w_inst", bus2.inst, 32'h1234_5678);
      force u_dut2.r_fetch_cnt = 32'hFFFF_FFFF;
      #1;
      check("w_forced", cnt2, 32'hFFFF_FFFF);
      release u_dut2.r_fetch_cnt;
      bus2.inst_ready = 1'b1;
      tick;
      bus2.inst_ready = 1'b0;
      check("w_cnt_wrap", cnt2, 32'd0);
      check("w_addr1", bus2.imem_addr, 32'h0);
      check("w_req1", {31'd0, bus2.imem_req}, 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
